ifft_deframer: RTL and testbench
================================

// Module: ifft_deframer
// PURPOSE
//  Receive side of the IFFT output stream: captures 64-sample time-domain bursts (data_out_en/re/im
//  of the IFFT stage), keeps the real part, and replays it one sample per audio tick to the
//  anti-noise DAC path. Ping-pong buffering decouples the burst rate from the audio sample rate.
//  Converts Q8.24 to saturated signed Q1.(OUT_W-1). Reports overflow/underrun via sticky flags.
// PARAMETERS
//  N      64  samples per frame (power of 2)
//  WIDTH  32  input word width, signed Q(WIDTH-24).24
//  FRAC   24  input fractional bits
//  OUT_W  24  output sample width, signed Q1.(OUT_W-1)
// PORTS
//  clk         in   1       clock
//  reset       in   1       synchronous, active-high reset
//  in_en       in   1       input beat valid; one frame = N beats, not necessarily contiguous
//  in_re       in   WIDTH   real sample, Q8.24
//  in_im       in   WIDTH   imaginary sample; ignored
//  sample_req  in   1       audio tick: one-cycle pulse requesting the next output sample
//  clr_status  in   1       clears overflow and underrun flags
//  out_valid   out  1       output sample strobe
//  out_sample  out  OUT_W   output sample
//  overflow    out  1       sticky: a frame was dropped
//  underrun    out  1       sticky: sample_req arrived with no full bank
//  frame_ready out  1       at least one bank is full
// BEHAVIOUR
//  Reset: all outputs 0, both banks empty, wr_bank=0, rd_bank=0, wr_idx=0, rd_idx=0, drop=0.
//   Reset mid-frame discards the partial frame and both buffered frames.
//  Write side, per in_en beat:
//   - drop=0 and full[wr_bank]=0: mem[wr_bank][wr_idx] <= conv(in_re); wr_idx++.
//   - beat with wr_idx=N-1: full[wr_bank] <= 1; wr_bank toggles; wr_idx <= 0.
//   - wr_idx=0 and full[wr_bank]=1: drop <= 1, overflow <= 1.
//     The beat and the rest of the frame are discarded; wr_idx still counts the dropped beats.
//     On the N-th dropped beat, drop <= 0 and wr_idx <= 0.
//   - Frame alignment is kept by beat count only.
//  Conversion conv(x) = sat_OUT_W(x >>> (FRAC-(OUT_W-1))), arithmetic shift, then clamp:
//   - values above the OUT_W range -> 2^(OUT_W-1)-1;
//   - values below the OUT_W range -> -2^(OUT_W-1).
//   Defaults: shift is 1.
//  Read side, on sample_req with latency 1 (out_valid high exactly the cycle after sample_req):
//   - full[rd_bank]=1: out_sample <= mem[rd_bank][rd_idx]; rd_idx++.
//     When rd_idx=N-1: full[rd_bank] <= 0; rd_bank toggles; rd_idx <= 0.
//   - full[rd_bank]=0: out_sample <= 0; underrun <= 1; rd_idx unchanged.
//  out_sample holds its value while out_valid is low.
//  Simultaneous events:
//   - Write completes bank A while read releases bank B in the same cycle: both take effect.
//   - Write completes bank X while rd_bank=X is empty and sample_req is high:
//     the read sees the pre-update (empty) state -> underrun. No write-to-read bypass.
//   - clr_status in the same cycle as a new overflow or underrun event: the set wins.
//  frame_ready = full[0] | full[1], registered.
// STRUCTURE
//  Shared package anc_pkg holds:
//   - constants WIDTH=32, FRAC=24, FFT_N=64;
//   - typedef sample_t (logic signed [WIDTH-1:0]);
//   - function sat_shift() used by conv.
//  One sub-module, deframe_bank_ram: 2*N x OUT_W, 1 write port and 1 registered read port,
//   addressed {bank, idx}. Inference-friendly, no reset on the array.
//  Top level holds the write and read counters, full[1:0], drop, and the status flags.
// TESTING
//  1. Reset, then one frame in_re = k<<24 for k=0..63, then 64 sample_req:
//     out_sample = 0, 2^23-1 (sat), 2^23-1, ...; sample 0 = 0; no flags set.
//  2. Frame of in_re = 32'h0040_0000 (0.25), then 64 reqs: each out_sample = 24'h20_0000.
//     in_re = 32'hFF00_0000 (-1.0): out = 24'h80_0000.
//  3. sample_req with both banks empty: out_valid next cycle, out_sample=0, underrun=1.
//     clr_status clears underrun.
//  4. Three back-to-back frames with no reqs: frames 1 and 2 are stored, frame 3 is dropped,
//     overflow=1. 128 reqs return frames 1 then 2. Frame 4 afterwards is stored correctly.
//  5. Drain bank 0 while frame 2 is being written (sample_req and in_en overlapping):
//     no data corruption; the last req of bank 0 and the last beat of the frame fall in one cycle.
//  6. Reset asserted after 20 beats of a frame, then a full new frame and 64 reqs:
//     only the new frame is output; flags are 0.

Source files
------------

// File: rtl/anc_pkg.sv
// Shared constants and helpers for the ANC signal path.
// sat_shift turns a Q8.24 word into a clamped narrower fixed-point value.
package anc_pkg;

    localparam int WIDTH = 32;
    localparam int FRAC  = 24;
    localparam int FFT_N = 64;

    typedef logic signed [WIDTH-1:0] sample_t;

    // Arithmetic right shift, then clamp into the signed range of an ow-bit word.
    // The result keeps full width; callers take the low ow bits.
    function automatic sample_t sat_shift(input sample_t x, input int sh, input int ow);
        sample_t s;
        sample_t hi;
        sample_t lo;
        s  = x >>> sh;
        hi = sample_t'((64'sd1 <<< (ow - 1)) - 64'sd1);
        lo = ~hi;
        if (s > hi)
            return hi;
        else if (s < lo)
            return lo;
        else
            return s;
    endfunction

endpackage

// File: rtl/deframe_bank_ram.sv
// Two-bank sample store addressed {bank, idx}: one write port, one registered read port.
// Plain array with no reset so it maps onto block RAM.
module deframe_bank_ram #(
    parameter int AW = 7,
    parameter int DW = 24
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ifft_deframer.sv
// Captures N-beat IFFT bursts into a ping-pong buffer and replays the real part,
// one saturated sample per audio tick, with sticky overflow/underrun status.
module ifft_deframer
    import anc_pkg::*;
#(
    parameter int N     = FFT_N,
    parameter int WIDTH = anc_pkg::WIDTH,
    parameter int FRAC  = anc_pkg::FRAC,
    parameter int OUT_W = 24
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_en,
    input  logic signed [WIDTH-1:0] in_re,
    input  logic signed [WIDTH-1:0] in_im,
    input  logic                    sample_req,
    input  logic                    clr_status,
    output logic                    out_valid,
    output logic [OUT_W-1:0]        out_sample,
    output logic                    overflow,
    output logic                    underrun,
    output logic                    frame_ready
);

    localparam int IDX_W = $clog2(N);
    localparam int SHIFT = FRAC - (OUT_W - 1);

    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic [1:0]       full_q, full_d;
    logic             drop_q, drop_d;
    logic             overflow_q, overflow_d;
    logic             underrun_q, underrun_d;
    logic             frame_ready_q, frame_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             rd_hit_q, rd_hit_d;

    logic             ram_we, ram_re;
    logic [OUT_W-1:0] ram_rdata;
    logic             ovf_set, unf_set;
    logic             wr_last, rd_last;
    sample_t          conv_full;
    logic             unused_ok;

    assign conv_full = sat_shift(sample_t'(in_re), SHIFT, OUT_W);
    assign unused_ok = ^{in_im, conv_full[WIDTH-1:OUT_W]};
    assign wr_last   = (wr_idx_q == IDX_W'(N - 1));
    assign rd_last   = (rd_idx_q == IDX_W'(N - 1));

    always_comb begin
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        wr_idx_d    = wr_idx_q;
        rd_idx_d    = rd_idx_q;
        full_d      = full_q;
        drop_d      = drop_q;
        rd_hit_d    = rd_hit_q;
        out_valid_d = sample_req;
        ram_we      = 1'b0;
        ram_re      = 1'b0;
        ovf_set     = 1'b0;
        unf_set     = 1'b0;

        // Read decisions look only at the registered full bits: a frame completing
        // this cycle is not visible to a simultaneous request.
        if (sample_req) begin
            if (full_q[rd_bank_q]) begin
                ram_re   = 1'b1;
                rd_hit_d = 1'b1;
                if (rd_last) begin
                    full_d[rd_bank_q] = 1'b0;
                    rd_bank_d         = ~rd_bank_q;
                    rd_idx_d          = '0;
                end else begin
                    rd_idx_d = rd_idx_q + 1'b1;
                end
            end else begin
                rd_hit_d = 1'b0;
                unf_set  = 1'b1;
            end
        end

        if (in_en) begin
            if (drop_q) begin
                if (wr_last) begin
                    drop_d   = 1'b0;
                    wr_idx_d = '0;
                end else begin
                    wr_idx_d = wr_idx_q + 1'b1;
                end
            end else if (full_q[wr_bank_q]) begin
                // Only reachable at a frame boundary; count this beat as the first dropped one.
                drop_d   = 1'b1;
                ovf_set  = 1'b1;
                wr_idx_d = wr_idx_q + 1'b1;
            end else begin
                ram_we = 1'b1;
                if (wr_last) begin
                    full_d[wr_bank_q] = 1'b1;
                    wr_bank_d         = ~wr_bank_q;
                    wr_idx_d          = '0;
                end else begin
                    wr_idx_d = wr_idx_q + 1'b1;
                end
            end
        end

        overflow_d    = (overflow_q & ~clr_status) | ovf_set;
        underrun_d    = (underrun_q & ~clr_status) | unf_set;
        frame_ready_d = |full_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_bank_q     <= 1'b0;
            rd_bank_q     <= 1'b0;
            wr_idx_q      <= '0;
            rd_idx_q      <= '0;
            full_q        <= '0;
            drop_q        <= 1'b0;
            overflow_q    <= 1'b0;
            underrun_q    <= 1'b0;
            frame_ready_q <= 1'b0;
            out_valid_q   <= 1'b0;
            rd_hit_q      <= 1'b0;
        end else begin
            wr_bank_q     <= wr_bank_d;
            rd_bank_q     <= rd_bank_d;
            wr_idx_q      <= wr_idx_d;
            rd_idx_q      <= rd_idx_d;
            full_q        <= full_d;
            drop_q        <= drop_d;
            overflow_q    <= overflow_d;
            underrun_q    <= underrun_d;
            frame_ready_q <= frame_ready_d;
            out_valid_q   <= out_valid_d;
            rd_hit_q      <= rd_hit_d;
        end
    end

    deframe_bank_ram #(
        .AW (IDX_W + 1),
        .DW (OUT_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr ({wr_bank_q, wr_idx_q}),
        .wdata (conv_full[OUT_W-1:0]),
        .re    (ram_re),
        .raddr ({rd_bank_q, rd_idx_q}),
        .rdata (ram_rdata)
    );

    // The read register only moves on a hit, so the sample holds between strobes.
    assign out_sample  = rd_hit_q ? ram_rdata : '0;
    assign out_valid   = out_valid_q;
    assign overflow    = overflow_q;
    assign underrun    = underrun_q;
    assign frame_ready = frame_ready_q;

endmodule

// File: tb/tb_ifft_deframer.sv
// Randomized bench for ifft_deframer against a frame-queue reference model.
module tb_ifft_deframer;

    localparam int N = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_en = 1'b0;
    logic [31:0] in_re = '0;
    logic [31:0] in_im = '0;
    logic        sample_req = 1'b0;
    logic        clr_status = 1'b0;
    logic        out_valid;
    logic [23:0] out_sample;
    logic        overflow;
    logic        underrun;
    logic        frame_ready;

    always #5 clk = ~clk;

    ifft_deframer dut (
        .clk         (clk),
        .reset       (reset),
        .in_en       (in_en),
        .in_re       (in_re),
        .in_im       (in_im),
        .sample_req  (sample_req),
        .clr_status  (clr_status),
        .out_valid   (out_valid),
        .out_sample  (out_sample),
        .overflow    (overflow),
        .underrun    (underrun),
        .frame_ready (frame_ready)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: complete frames waiting to be played, plus the frame being received.
    logic [23:0] fifo[$];
    logic [23:0] cur[$];
    int          nfull, rd_cnt, wcnt;
    bit          dropping;
    logic        exp_valid, exp_ovf, exp_unf, exp_rdy;
    logic [23:0] exp_sample;
    bit          chk_en = 0;
    logic [23:0] got[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Q8.24 value scaled to Q1.23 units, rounded toward minus infinity, then clamped.
    function automatic logic [23:0] ref_conv(input logic [31:0] x);
        longint v, q;
        v = longint'($signed(x));
        q = longint'($floor(real'(v) / 2.0));
        if (q > 8388607)  q = 8388607;
        if (q < -8388608) q = -8388608;
        return 24'(q);
    endfunction

    task automatic model_step(input logic en, input logic [31:0] re, input logic req,
                              input logic clr, input logic rst);
        int  pre;
        bit  release_f, complete, ovf, unf;
        if (rst) begin
            fifo.delete(); cur.delete();
            nfull = 0; rd_cnt = 0; wcnt = 0; dropping = 0;
            exp_valid = 0; exp_ovf = 0; exp_unf = 0; exp_rdy = 0; exp_sample = '0;
            return;
        end
        pre = nfull; release_f = 0; complete = 0; ovf = 0; unf = 0;
        exp_valid = req;
        if (req) begin
            if (nfull > 0) begin
                exp_sample = fifo.pop_front();
                rd_cnt++;
                if (rd_cnt == N) begin rd_cnt = 0; release_f = 1; end
            end else begin
                exp_sample = '0;
                unf = 1;
            end
        end
        if (en) begin
            if (dropping) begin
                wcnt++;
                if (wcnt == N) begin wcnt = 0; dropping = 0; end
            end else if (wcnt == 0 && pre == 2) begin
                dropping = 1; ovf = 1; wcnt = 1;
            end else begin
                cur.push_back(ref_conv(re));
                wcnt++;
                if (wcnt == N) begin wcnt = 0; complete = 1; end
            end
        end
        if (release_f) nfull--;
        if (complete) begin
            foreach (cur[i]) fifo.push_back(cur[i]);
            cur.delete();
            nfull++;
        end
        exp_ovf = (exp_ovf && !clr) || ovf;
        exp_unf = (exp_unf && !clr) || unf;
        exp_rdy = (nfull > 0);
    endtask

    task automatic step(input logic en, input logic [31:0] re, input logic req,
                        input logic clr, input logic rst);
        @(negedge clk);
        reset = rst; in_en = en; in_re = re; in_im = $urandom;
        sample_req = req; clr_status = clr;
        model_step(en, re, req, clr, rst);
        chk_en = 1;
    endtask

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("out_valid",   32'(out_valid),   32'(exp_valid));
            chk("out_sample",  32'(out_sample),  32'(exp_sample));
            chk("overflow",    32'(overflow),    32'(exp_ovf));
            chk("underrun",    32'(underrun),    32'(exp_unf));
            chk("frame_ready", 32'(frame_ready), 32'(exp_rdy));
            if (out_valid) got.push_back(out_sample);
        end
    end

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'($signed($urandom_range(0, 32'h01FF_FFFF)) - 32'sh0100_0000);
            2:       return $urandom_range(0, 1) ? 32'h7FFF_FFFF : 32'h8000_0000;
            default: return $urandom_range(0, 1) ? 32'h00FF_FFFE : 32'hFF00_0001;
        endcase
    endfunction

    // mode 0: k<<24, 1: constant val, 2: random, 3: k<<16
    task automatic send_frame(input int mode, input logic [31:0] val);
        logic [31:0] w;
        for (int k = 0; k < N; k++) begin
            case (mode)
                0:       w = 32'(k) << 24;
                1:       w = val;
                2:       w = rnd_word();
                default: w = 32'(k) << 16;
            endcase
            step(1'b1, w, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic reqs(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, '0, 1'b1, 1'b0, 1'b0);
            step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // 1: ramp k<<24 saturates for k>=1
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        idle(2);
        chk("reset_out_sample", 32'(out_sample), 32'h0);
        got.delete();
        send_frame(0, '0);
        idle(1);
        chk("t1_frame_ready", 32'(frame_ready), 32'h1);
        reqs(N);
        chk("t1_count", 32'(got.size()), 32'd64);
        chk("t1_s0",  32'(got[0]),  32'h0);
        chk("t1_s1",  32'(got[1]),  32'h7FFFFF);
        chk("t1_s63", 32'(got[63]), 32'h7FFFFF);
        chk("t1_flags", 32'({overflow, underrun}), 32'h0);

        // 2: 0.25 and -1.0
        got.delete();
        send_frame(1, 32'h0040_0000);
        reqs(N);
        chk("t2_quarter", 32'(got[10]), 32'h200000);
        got.delete();
        send_frame(1, 32'hFF00_0000);
        reqs(N);
        chk("t2_minus1", 32'(got[5]), 32'h800000);

        // 3: underrun on empty buffer, then clear
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle(1);
        chk("t3_underrun", 32'(underrun), 32'h1);
        chk("t3_zero", 32'(out_sample), 32'h0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        idle(1);
        chk("t3_cleared", 32'(underrun), 32'h0);

        // 4: third frame dropped, first two replayed, fourth stored
        send_frame(2, '0);
        send_frame(2, '0);
        send_frame(2, '0);
        idle(1);
        chk("t4_overflow", 32'(overflow), 32'h1);
        got.delete();
        reqs(2 * N);
        chk("t4_count", 32'(got.size()), 32'd128);
        send_frame(2, '0);
        reqs(N);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);

        // 5: drain bank while next frame arrives; last req and last beat coincide
        send_frame(2, '0);
        for (int k = 0; k < N; k++) step(1'b1, rnd_word(), 1'b1, 1'b0, 1'b0);
        reqs(N);

        // 6: reset mid-frame discards everything
        for (int k = 0; k < 20; k++) step(1'b1, rnd_word(), 1'b0, 1'b0, 1'b0);
        send_frame(2, '0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        idle(1);
        chk("t6_ready_after_reset", 32'(frame_ready), 32'h0);
        got.delete();
        send_frame(3, '0);
        reqs(N);
        chk("t6_count", 32'(got.size()), 32'd64);
        chk("t6_s1",  32'(got[1]),  32'h008000);
        chk("t6_s63", 32'(got[63]), 32'h1F8000);
        chk("t6_flags", 32'({overflow, underrun}), 32'h0);

        // random traffic
        for (int i = 0; i < 4000; i++)
            step(1'($urandom_range(0, 1)), rnd_word(), 1'($urandom_range(0, 9) < 3),
                 1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1999) == 0));
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
